// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the IF/DM memory arbiter: read-owner state encodings
// and the default starvation limit.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_RD_IF = 2'b01,
    ARB_RD_DM = 2'b10
  } arb_state_e;

  localparam int unsigned STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of consecutive cycles a requester was denied; at_max flags
// that the requester must win the next arbitration.
module mem_arb_starve_cnt
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic gnt,
  output logic at_max
);

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (gnt || !req) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign at_max = (cnt == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (IF/DM) arbiter in front of a single-port synchronous RAM.
// Optional wait-cycle counters are enabled by defining MEM_ARB_PERF_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  dm_req,
  input  logic [DATA_W/8-1:0]   dm_wea,
  input  logic [ADDR_W-1:0]     dm_addr,
  input  logic [DATA_W-1:0]     dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [DATA_W-1:0]     dm_rdata,
  output logic                  ram_ena,
  output logic [DATA_W/8-1:0]   ram_wea,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]           perf_if_wait,
  output logic [31:0]           perf_dm_wait,
`endif
  input  logic [DATA_W-1:0]     ram_rdata
);

  arb_state_e state, state_nxt;
  logic       if_at_max;

  mem_arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .req   (if_req),
    .gnt   (if_gnt),
    .at_max(if_at_max)
  );

  // DM has priority unless IF has been starved for STARVE_MAX cycles;
  // nothing is granted while reset is held.
  assign if_gnt = rst & if_req & (~dm_req | if_at_max);
  assign dm_gnt = rst & dm_req & ~if_gnt;

  always_comb begin
    ram_ena   = 1'b0;
    ram_wea   = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (if_gnt) begin
      ram_ena  = 1'b1;
      ram_addr = if_addr;
    end else if (dm_gnt) begin
      ram_ena   = 1'b1;
      ram_wea   = dm_wea;
      ram_addr  = dm_addr;
      ram_wdata = dm_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = ARB_IDLE;
    if (if_gnt) begin
      state_nxt = ARB_RD_IF;
    end else if (dm_gnt && dm_wea == '0) begin
      state_nxt = ARB_RD_DM;
    end
  end

  assign if_rvalid = (state == ARB_RD_IF);
  assign dm_rvalid = (state == ARB_RD_DM);
  assign if_rdata  = if_rvalid ? ram_rdata : '0;
  assign dm_rdata  = dm_rvalid ? ram_rdata : '0;

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_if_wait <= '0;
      perf_dm_wait <= '0;
    end else begin
      if (if_req && !if_gnt) perf_if_wait <= perf_if_wait + 32'd1;
      if (dm_req && !dm_gnt) perf_dm_wait <= perf_dm_wait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// starvation/reset sequences, then randomized traffic against a reference model.
module tb_mem_arbiter;

  localparam int SMAX = 4;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic [3:0]  dm_wea;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        ram_ena;
  logic [3:0]  ram_wea;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_wait;
  logic [31:0] perf_dm_wait;
`endif

  mem_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .dm_req   (dm_req),
    .dm_wea   (dm_wea),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_gnt   (dm_gnt),
    .dm_rvalid(dm_rvalid),
    .dm_rdata (dm_rdata),
    .ram_ena  (ram_ena),
    .ram_wea  (ram_wea),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
`ifdef MEM_ARB_PERF_EN
    .perf_if_wait(perf_if_wait),
    .perf_dm_wait(perf_dm_wait),
`endif
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int unsigned i);
    return (i == 4) ? 32'hDEADBEEF : (32'hC0DE0000 + 32'(i) * 32'h00010001);
  endfunction

  // RAM model: 256 words, write with byte enables, read data one cycle later.
  logic [31:0] mem [256];
  logic        ram_load;
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (ram_ena) begin
      if (ram_wea != 4'b0) begin
        for (int b = 0; b < 4; b++)
          if (ram_wea[b]) mem[ram_addr[9:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end else begin
        ram_rdata <= mem[ram_addr[9:2]];
      end
    end
  end

  int n_vec;
  int n_err;
  logic [31:0] shadow [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sh_write(input logic [31:0] addr, input logic [3:0] wea, input logic [31:0] wd);
    for (int b = 0; b < 4; b++)
      if (wea[b]) shadow[addr[9:2]][b*8 +: 8] = wd[b*8 +: 8];
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    if_req   = 1'b0;
    if_addr  = '0;
    dm_req   = 1'b0;
    dm_wea   = '0;
    dm_addr  = '0;
    dm_wdata = '0;
  endtask

  typedef struct {
    logic        ir;
    logic        dr;
    logic [3:0]  wea;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] wd;
    logic        eig;
    logic        edg;
    logic        eirv;
    logic        edrv;
    logic        crd;
    logic [31:0] erd;
  } vec_t;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  vec_t        tbl [15];
  logic [31:0] w_tmp;
  logic [31:0] merged;
  logic [31:0] eaddr;

  // reference-model state for the random phase
  int          m_wait;
  logic        p_if, p_dm;
  logic [31:0] p_data;
  logic        e_ig, e_dg;
  logic        hold_if, hold_dm;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    ram_load = 1'b1;
    idle_inputs();
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    @(posedge clk);
    #1;
    ram_load = 1'b0;

    // reset state: outputs quiet, requests ignored
    if_req = 1'b1;
    dm_req = 1'b1;
    #1;
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_dm_gnt", 32'(dm_gnt), 32'd0);
    chk("rst_ram_ena", 32'(ram_ena), 32'd0);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_dm_rvalid", 32'(dm_rvalid), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
`ifdef MEM_ARB_PERF_EN
    chk("rst_perf_if", perf_if_wait, 32'd0);
    chk("rst_perf_dm", perf_dm_wait, 32'd0);
`endif
    idle_inputs();
    cyc();
    rst = 1'b1;

    w_tmp  = init_word(16);
    merged = {w_tmp[31:16], 16'hABCD};
    //            ir dr wea   ia      da       wd            eig edg eirv edrv crd erd
    tbl[0]  = '{T, F, 4'h0, 32'h10, 32'h0,   32'h0,        T, F, F, F, F, 32'h0};
    tbl[1]  = '{T, T, 4'h0, 32'h14, 32'h200, 32'h0,        F, T, T, F, T, 32'hDEADBEEF};
    tbl[2]  = '{T, T, 4'h0, 32'h14, 32'h204, 32'h0,        F, T, F, T, T, init_word(128)};
    tbl[3]  = '{T, T, 4'h0, 32'h14, 32'h208, 32'h0,        F, T, F, T, T, init_word(129)};
    tbl[4]  = '{T, T, 4'h0, 32'h14, 32'h20C, 32'h0,        F, T, F, T, T, init_word(130)};
    tbl[5]  = '{T, T, 4'h0, 32'h14, 32'h210, 32'h0,        T, F, F, T, T, init_word(131)};
    tbl[6]  = '{T, T, 4'h0, 32'h18, 32'h210, 32'h0,        F, T, T, F, T, init_word(5)};
    tbl[7]  = '{F, T, 4'hF, 32'h0,  32'h80,  32'h55AA55AA, F, T, F, T, T, init_word(132)};
    tbl[8]  = '{F, F, 4'h0, 32'h0,  32'h0,   32'h0,        F, F, F, F, F, 32'h0};
    tbl[9]  = '{T, T, 4'h3, 32'h18, 32'h40,  32'h1234ABCD, F, T, F, F, F, 32'h0};
    tbl[10] = '{F, F, 4'h0, 32'h0,  32'h0,   32'h0,        F, F, F, F, F, 32'h0};
    tbl[11] = '{F, T, 4'h0, 32'h0,  32'h40,  32'h0,        F, T, F, F, F, 32'h0};
    tbl[12] = '{F, F, 4'h0, 32'h0,  32'h0,   32'h0,        F, F, F, T, T, merged};
    tbl[13] = '{T, F, 4'h0, 32'h80, 32'h0,   32'h0,        T, F, F, F, F, 32'h0};
    tbl[14] = '{F, F, 4'h0, 32'h0,  32'h0,   32'h0,        F, F, T, F, T, 32'h55AA55AA};

    for (int i = 0; i < 15; i++) begin
      if_req   = tbl[i].ir;
      if_addr  = tbl[i].ia;
      dm_req   = tbl[i].dr;
      dm_wea   = tbl[i].wea;
      dm_addr  = tbl[i].da;
      dm_wdata = tbl[i].wd;
      @(negedge clk);
      eaddr = tbl[i].eig ? tbl[i].ia : (tbl[i].edg ? tbl[i].da : 32'h0);
      chk("tbl_if_gnt", 32'(if_gnt), 32'(tbl[i].eig));
      chk("tbl_dm_gnt", 32'(dm_gnt), 32'(tbl[i].edg));
      chk("tbl_if_rvalid", 32'(if_rvalid), 32'(tbl[i].eirv));
      chk("tbl_dm_rvalid", 32'(dm_rvalid), 32'(tbl[i].edrv));
      chk("tbl_ram_ena", 32'(ram_ena), 32'(tbl[i].eig | tbl[i].edg));
      chk("tbl_ram_addr", ram_addr, eaddr);
      chk("tbl_ram_wea", 32'(ram_wea), tbl[i].edg ? 32'(tbl[i].wea) : 32'h0);
      if (tbl[i].crd)
        chk("tbl_rdata", tbl[i].eirv ? if_rdata : dm_rdata, tbl[i].erd);
      if (tbl[i].edg && tbl[i].wea != 4'h0) sh_write(tbl[i].da, tbl[i].wea, tbl[i].wd);
      cyc();
    end

    // steady contention: DM four times, then IF once, repeating
    for (int k = 0; k < 15; k++) begin
      if_req  = 1'b1;
      if_addr = 32'h100;
      dm_req  = 1'b1;
      dm_wea  = '0;
      dm_addr = 32'h104;
      @(negedge clk);
      chk("pat_if_gnt", 32'(if_gnt), 32'((k % 5) == 4));
      chk("pat_dm_gnt", 32'(dm_gnt), 32'((k % 5) != 4));
      cyc();
    end

    // starvation count and in-flight DM read are cleared by reset
    for (int k = 0; k < 3; k++) cyc();
    @(negedge clk);
    chk("rstdm_dm_gnt", 32'(dm_gnt), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("rstdm_dm_rvalid", 32'(dm_rvalid), 32'd0);
    chk("rstdm_dm_rdata", dm_rdata, 32'd0);
    chk("rstdm_dm_gnt_low", 32'(dm_gnt), 32'd0);
    chk("rstdm_ram_ena", 32'(ram_ena), 32'd0);
    idle_inputs();
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("rstdm_rvalid_after", 32'(dm_rvalid), 32'd0);
`ifdef MEM_ARB_PERF_EN
    chk("perf_if_zero", perf_if_wait, 32'd0);
    chk("perf_dm_zero", perf_dm_wait, 32'd0);
`endif
    cyc();
    for (int k = 0; k < 5; k++) begin
      if_req  = 1'b1;
      if_addr = 32'h100;
      dm_req  = 1'b1;
      dm_addr = 32'h104;
      @(negedge clk);
      chk("post_rst_if_gnt", 32'(if_gnt), 32'(k == 4));
      cyc();
    end
`ifdef MEM_ARB_PERF_EN
    chk("perf_if_wait", perf_if_wait, 32'd4);
    chk("perf_dm_wait", perf_dm_wait, 32'd1);
`endif
    idle_inputs();
    cyc();

    // in-flight IF read killed by reset
    if_req  = 1'b1;
    if_addr = 32'h10;
    @(negedge clk);
    chk("rstif_if_gnt", 32'(if_gnt), 32'd1);
    cyc();
    idle_inputs();
    chk("rstif_rvalid_pre", 32'(if_rvalid), 32'd1);
    rst = 1'b0;
    #1;
    chk("rstif_rvalid", 32'(if_rvalid), 32'd0);
    chk("rstif_rdata", if_rdata, 32'd0);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("rstif_rvalid_after", 32'(if_rvalid), 32'd0);
    cyc();
    cyc();

    // randomized traffic against the reference model
    m_wait  = 0;
    p_if    = 1'b0;
    p_dm    = 1'b0;
    p_data  = '0;
    hold_if = 1'b0;
    hold_dm = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (!hold_if) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = 32'($urandom_range(0, 255)) << 2;
      end
      if (!hold_dm) begin
        dm_req   = ($urandom_range(0, 2) != 0);
        dm_wea   = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
        dm_addr  = 32'($urandom_range(0, 255)) << 2;
        dm_wdata = $urandom;
      end
      @(negedge clk);
      e_ig = if_req && (!dm_req || m_wait == SMAX);
      e_dg = dm_req && !e_ig;
      eaddr = e_ig ? if_addr : (e_dg ? dm_addr : 32'h0);
      chk("rnd_if_gnt", 32'(if_gnt), 32'(e_ig));
      chk("rnd_dm_gnt", 32'(dm_gnt), 32'(e_dg));
      chk("rnd_ram_ena", 32'(ram_ena), 32'(e_ig | e_dg));
      chk("rnd_ram_addr", ram_addr, eaddr);
      chk("rnd_ram_wea", 32'(ram_wea), e_dg ? 32'(dm_wea) : 32'h0);
      chk("rnd_ram_wdata", ram_wdata, e_dg ? dm_wdata : 32'h0);
      chk("rnd_if_rvalid", 32'(if_rvalid), 32'(p_if));
      chk("rnd_dm_rvalid", 32'(dm_rvalid), 32'(p_dm));
      chk("rnd_if_rdata", if_rdata, p_if ? p_data : 32'h0);
      chk("rnd_dm_rdata", dm_rdata, p_dm ? p_data : 32'h0);
      p_if   = e_ig;
      p_dm   = e_dg && (dm_wea == 4'h0);
      p_data = shadow[eaddr[9:2]];
      if (e_dg && dm_wea != 4'h0) sh_write(dm_addr, dm_wea, dm_wdata);
      m_wait  = (if_req && !e_ig) ? ((m_wait < SMAX) ? m_wait + 1 : SMAX) : 0;
      hold_if = if_req && !e_ig;
      hold_dm = dm_req && !e_dg;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
